// File: rtl/arb_pkg.sv
// Shared constants for the arbiter requester block: FSM state encoding,
// default burst length and counter width, and the counter maximum.
package arb_pkg;

    localparam int BURST_LEN_DEF = 4;
    localparam int CNT_W_DEF     = 4;
    localparam int CNT_MAX_DEF   = (1 << CNT_W_DEF) - 1;

    // Per-channel FSM encoding (legacy-compatible constants)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Saturation value of a pending-job counter of the given width
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: pending-job counter plus the IDLE/REQ/XFER/GAP
// burst FSM. Reports abort (grant lost mid-burst) to the top for error
// tracking.
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       grant,
    output logic       req,
    output logic       xfer,
    output logic [3:0] beat_idx,
    output logic       full,
    output logic       ovf,
    output logic       abort
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));
    localparam logic [3:0]       LAST_BEAT = 4'(BURST_LEN - 1);

    logic [1:0]       state;
    logic [3:0]       beat;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             done;
    logic             drop;

    assign xfer     = (state == ST_XFER);
    assign req      = (state == ST_REQ) || xfer;
    assign beat_idx = beat;
    assign full     = (count == CNT_MAX);
    assign abort    = xfer && !grant;
    assign done     = xfer && grant && (beat == LAST_BEAT);

    // Burst FSM and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (grant) begin
                        state <= ST_XFER;
                        beat  <= '0;
                    end
                end
                ST_XFER: begin
                    if (!grant || beat == LAST_BEAT) begin
                        state <= ST_GAP;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end
                ST_GAP: begin
                    state <= (count != '0) ? ST_REQ : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Next pending count: push and completion on one edge cancel out
    always_comb begin
        count_nxt = count;
        drop      = 1'b0;
        if (push && !done) begin
            if (full) drop = 1'b1;
            else      count_nxt = count + 1'b1;
        end else if (!push && done) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pending-job counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count_nxt;
    end

    // Sticky overflow flag for dropped pushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
    end

endmodule

// File: rtl/arb_requester.sv
// N-channel burst requester facing an external arbiter. Each channel owns
// its FSM and job counter; this level muxes the beat outputs and tracks
// arbiter protocol violations.
module arb_requester
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         job_push,
    input  logic [N-1:0]         grant,
    output logic [N-1:0]         req,
    output logic                 beat_valid,
    output logic [$clog2(N)-1:0] beat_ch,
    output logic [3:0]           beat_idx,
    output logic [N-1:0]         pend_full,
    output logic [N-1:0]         ovf,
    output logic                 proto_err
);

    localparam int CH_W = $clog2(N);

    logic [N-1:0] xfer;
    logic [N-1:0] abort;
    logic [3:0]   chan_beat [N];
    logic         multi_grant;
    logic         stray_grant;

    for (genvar i = 0; i < N; i++) begin : g_chan
        arb_req_chan #(
            .BURST_LEN (BURST_LEN),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .push     (job_push[i]),
            .grant    (grant[i]),
            .req      (req[i]),
            .xfer     (xfer[i]),
            .beat_idx (chan_beat[i]),
            .full     (pend_full[i]),
            .ovf      (ovf[i]),
            .abort    (abort[i])
        );
    end

    assign multi_grant = (grant & (grant - N'(1))) != '0;
    assign stray_grant = (grant & ~req) != '0;

    // Beat mux: lowest-index transferring channel wins, zeros when idle
    always_comb begin
        logic found;
        found      = 1'b0;
        beat_valid = 1'b0;
        beat_ch    = '0;
        beat_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (xfer[i] && !found) begin
                found      = 1'b1;
                beat_valid = 1'b1;
                beat_ch    = CH_W'(i);
                beat_idx   = chan_beat[i];
            end
        end
    end

    // Sticky protocol error: multi-hot grant, grant without request, or
    // grant withdrawn during a burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            proto_err <= 1'b0;
        else if (multi_grant || stray_grant || (abort != '0))
            proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a transaction-level reference
// model checked every cycle, plus literal expectations at key points.
module tb_arb_requester;

    localparam int N   = 4;
    localparam int BL  = 4;
    localparam int MAX = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] job_push = '0;
    logic [N-1:0] grant;
    logic [N-1:0] grant_force = '0;
    logic         fpa_en = 1'b1;
    logic [N-1:0] req;
    logic         beat_valid;
    logic [1:0]   beat_ch;
    logic [3:0]   beat_idx;
    logic [N-1:0] pend_full;
    logic [N-1:0] ovf;
    logic         proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Fixed-priority arbiter partner, or a forced grant vector
    assign grant = fpa_en ? (req & (~req + 4'd1)) : grant_force;

    arb_requester #(.N(N), .BURST_LEN(BL), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_push   (job_push),
        .grant      (grant),
        .req        (req),
        .beat_valid (beat_valid),
        .beat_ch    (beat_ch),
        .beat_idx   (beat_idx),
        .pend_full  (pend_full),
        .ovf        (ovf),
        .proto_err  (proto_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: jobs waiting, beats left in the current burst,
    // one idle cycle after every burst end.
    int   m_cnt  [N];
    bit   m_wait [N];
    int   m_left [N];
    bit   m_rest [N];
    logic [N-1:0] m_ovf;
    bit   m_perr;

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_wait[i] || (m_left[i] > 0);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_wait[i] = 0; m_left[i] = 0; m_rest[i] = 0;
            end
            m_ovf  = '0;
            m_perr = 0;
        end else begin
            logic [N-1:0] g, p, rq;
            g  = grant;
            p  = job_push;
            rq = m_req();
            if ($countones(g) > 1 || (g & ~rq) != '0) m_perr = 1;
            for (int i = 0; i < N; i++) begin
                int dec;
                dec = 0;
                if (m_left[i] > 0) begin
                    if (!g[i]) begin
                        m_perr = 1; m_left[i] = 0; m_rest[i] = 1;
                    end else if (m_left[i] == 1) begin
                        m_left[i] = 0; m_rest[i] = 1; dec = 1;
                    end else begin
                        m_left[i] = m_left[i] - 1;
                    end
                end else if (m_wait[i]) begin
                    if (g[i]) begin
                        m_wait[i] = 0; m_left[i] = BL;
                    end
                end else if (m_rest[i]) begin
                    m_rest[i] = 0;
                    m_wait[i] = (m_cnt[i] > 0);
                end else begin
                    m_wait[i] = (m_cnt[i] > 0);
                end
                if (p[i] && dec == 0 && m_cnt[i] == MAX) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + int'(p[i]) - dec;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the edge
    always @(posedge clk) begin
        logic       e_bv;
        int         e_ch, e_idx;
        logic [N-1:0] e_full;
        #2;
        e_bv = 0; e_ch = 0; e_idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_left[i] > 0) begin
                e_bv = 1; e_ch = i; e_idx = BL - m_left[i];
            end
        end
        for (int i = 0; i < N; i++) e_full[i] = (m_cnt[i] == MAX);
        check("m_req",       req,        m_req());
        check("m_beat_valid", beat_valid, e_bv);
        check("m_beat_ch",   beat_ch,    e_ch);
        check("m_beat_idx",  beat_idx,   e_idx);
        check("m_pend_full", pend_full,  e_full);
        check("m_ovf",       ovf,        m_ovf);
        check("m_proto_err", proto_err,  m_perr);
    end

    task automatic push_n(input logic [N-1:0] m, input int n);
        job_push = m;
        repeat (n) @(negedge clk);
        job_push = '0;
    endtask

    task automatic chk_beat(input string name, input int ch, input int idx);
        check({name, "_valid"}, beat_valid, 1);
        check({name, "_ch"},    beat_ch,    ch);
        check({name, "_idx"},   beat_idx,   idx);
    endtask

    task automatic chk_zero(input string name);
        check({name, "_req"},  req,        0);
        check({name, "_bv"},   beat_valid, 0);
        check({name, "_ch"},   beat_ch,    0);
        check({name, "_idx"},  beat_idx,   0);
        check({name, "_full"}, pend_full,  0);
        check({name, "_ovf"},  ovf,        0);
        check({name, "_perr"}, proto_err,  0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 chk_zero("reset_pulse");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [18:0] pat;

        #12 chk_zero("reset_state");
        @(negedge clk);                    // t=20: release reset, push ch3
        rst = 1'b0;

        // Single job on ch3
        push_n(4'b1000, 1);
        @(negedge clk);
        check("single_req", req, 4'b1000);
        for (int b = 0; b < BL; b++) begin
            @(negedge clk);
            chk_beat("single_beat", 3, b);
        end
        @(negedge clk);
        check("single_req_end", req, 4'b0000);
        check("single_perr", proto_err, 0);
        repeat (3) @(negedge clk);

        // Contention ch0 vs ch3
        push_n(4'b1001, 1);
        @(negedge clk);
        check("cont_req", req, 4'b1001);
        for (int b = 0; b < BL; b++) begin
            @(negedge clk);
            chk_beat("cont_ch0", 0, b);
        end
        @(negedge clk);
        check("cont_gap_req", req, 4'b1000);
        check("cont_gap_bv", beat_valid, 0);
        for (int b = 0; b < BL; b++) begin
            @(negedge clk);
            chk_beat("cont_ch3", 3, b);
        end
        repeat (3) @(negedge clk);

        // Back-to-back: three jobs on ch1
        push_n(4'b0010, 3);
        pat = '0;
        for (int k = 0; k < 19; k++) begin
            pat = {pat[17:0], req[1]};
            @(negedge clk);
        end
        check("b2b_req1_pattern", pat, 19'b1111011111011111000);
        check("b2b_req_end", req, 4'b0000);

        // Saturation on ch2 with no grants
        fpa_en = 1'b0;
        grant_force = '0;
        push_n(4'b0100, 15);
        check("sat15_full", pend_full, 4'b0100);
        check("sat15_ovf", ovf, 4'b0000);
        push_n(4'b0100, 1);
        check("sat16_full", pend_full, 4'b0100);
        check("sat16_ovf", ovf, 4'b0100);
        check("sat_perr", proto_err, 0);

        // Grant dropped mid-burst on ch2
        grant_force = 4'b0100;
        @(negedge clk);
        chk_beat("abort_b0", 2, 0);
        @(negedge clk);
        chk_beat("abort_b1", 2, 1);
        grant_force = '0;
        @(negedge clk);
        check("abort_bv", beat_valid, 0);
        check("abort_req", req, 4'b0000);
        check("abort_perr", proto_err, 1);
        check("abort_full", pend_full, 4'b0100);
        @(negedge clk);
        check("abort_rereq", req, 4'b0100);

        // Multi-hot grant to non-requesting channels
        pulse_reset();
        grant_force = 4'b0011;
        @(negedge clk);
        check("multi_perr", proto_err, 1);
        grant_force = '0;
        repeat (3) @(negedge clk);
        check("multi_sticky", proto_err, 1);

        // Mixed traffic with the arbiter partner, checked by the model
        pulse_reset();
        fpa_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            job_push = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            @(negedge clk);
        end
        job_push = '0;

        // Reset in the middle of a burst
        pulse_reset();
        push_n(4'b0110, 1);
        @(negedge clk);
        check("rmb_req", req, 4'b0110);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk_beat("rmb_beat", 1, b);
        end
        #2 rst = 1'b1;
        #1 chk_zero("rmb_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rmb_no_pending", req, 4'b0000);
        check("rmb_no_beat", beat_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
